// File: rtl/mips_regfile_mp_if.sv
// Register file port bundle: read addresses/data, write port, clear request and status.
// The master side is decode/writeback; the slave side is mips_regfile_mp.
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       clear_req;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       ready;
    logic                       wr_drop;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, ready, wr_drop
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, ready, wr_drop
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with registered reads and a clear sweep.
// Define MIPS_REGFILE_BYPASS_EN to forward same-edge writes to the read ports.

module mips_regfile_rd_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              force_zero,
    input  logic              fwd,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)          q <= '0;
        else if (force_zero) q <= '0;
        else if (fwd)        q <= fwd_data;
        else                 q <= word;
    end
endmodule

module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst_n,
    mips_regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                          state;
    logic [ADDR_W-1:0]               cnt;
    logic                            ready_q;
    logic                            drop_q;
    logic [DATA_W-1:0]               mem [DEPTH];
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_q;

    logic zero_wr;
    logic wr_do;

    assign zero_wr = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign wr_do   = (state == READY) && bus.wr_en && !bus.clear_req && !zero_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= bus.wr_en && ((state == CLEAR) || bus.clear_req || zero_wr);
            case (state)
                CLEAR: begin
                    // Counter wraps back to 0 on the final entry.
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // The array holds its contents through reset; the sweep zeroes it afterwards.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) mem[cnt]         <= '0;
            else if (wr_do)     mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              force_zero;
        logic              fwd;

        assign addr       = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign force_zero = (state == CLEAR) || ((ZERO_REG != 0) && (addr == '0));
`ifdef MIPS_REGFILE_BYPASS_EN
        assign fwd        = wr_do && (addr == bus.wr_addr);
`else
        assign fwd        = 1'b0;
`endif

        mips_regfile_rd_lane #(.DATA_W(DATA_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .force_zero (force_zero),
            .fwd        (fwd),
            .fwd_data   (bus.wr_data),
            .word       (mem[addr]),
            .q          (rd_q[i])
        );
    end

    assign bus.rd_data = rd_q;
    assign bus.ready   = ready_q;
    assign bus.wr_drop = drop_q;
endmodule
